// File: rtl/rf_pkg.sv
// Shared helpers for the ID-stage register file: address width, counter ceiling, port slicing.
// Pure functions only; no state, no timing.
// No flow control of its own.
package rf_pkg;

    function automatic int rf_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int rf_cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // Low bit of port idx in a flat bus of w-bit lanes
    function automatic int rf_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters; gates issue and flags busy sources (RF_BYPASS_EN aware).
// Busy/ready are combinational; counters update at the next posedge.
// iss_ready drops while a used source is busy, the destination counter is full, or flush is high.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int CNT_W = 2,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR-1:0]    wr_retire,
    input  logic              iss_valid,
    input  logic [2*AW-1:0]   iss_src,
    input  logic [1:0]        iss_use,
    input  logic              iss_wen,
    input  logic [AW-1:0]     iss_dst,
    output logic              iss_ready,
    input  logic              flush
);

    localparam int CMAX = rf_cnt_max(CNT_W);
    localparam int DW   = $clog2(NWR + 1);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [DW-1:0]    dec     [NREG];
    logic [NREG-1:0]  busy_r;
    logic [NREG-1:0]  under_r;
    logic             iss_fire;
    logic             dst_full;
    int               sum;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_retire[j] && wr_addr[rf_lo(j, AW) +: AW] == AW'(r))
                    dec[r] = dec[r] + DW'(1);
            end
        end
    end

    always_comb begin
        busy_r = '0;
        for (int r = 1; r < NREG; r++) begin
`ifdef RF_BYPASS_EN
            // A same-cycle retire that drains the counter already frees the source
            busy_r[r] = int'(cnt[r]) > int'(dec[r]);
`else
            busy_r[r] = cnt[r] != '0;
`endif
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++)
            rd_busy[i] = busy_r[rd_addr[rf_lo(i, AW) +: AW]];
    end

    assign dst_full  = iss_wen && (cnt[iss_dst] == CNT_W'(CMAX));
    assign iss_ready = !flush
                     && !(iss_use[0] && busy_r[iss_src[AW-1:0]])
                     && !(iss_use[1] && busy_r[iss_src[2*AW-1:AW]])
                     && !dst_full;
    assign iss_fire  = iss_valid && iss_ready;

    always_comb begin
        sum     = 0;
        under_r = '0;
        for (int r = 0; r < NREG; r++) begin
            sum = int'(cnt[r]) - int'(dec[r]);
            if (r != 0 && iss_fire && iss_wen && iss_dst == AW'(r))
                sum = sum + 1;
            under_r[r] = sum < 0;
            cnt_nxt[r] = (sum < 0) ? '0 : CNT_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(under_r != '0 && !flush));

endmodule

// File: rtl/id_regfile_sb.sv
// Multi-port ID register file with pending-write scoreboard; optional same-cycle write bypass (RF_BYPASS_EN).
// Reads are zero-cycle combinational; writes commit at posedge (highest port wins).
// Issue handshake: iss_ready from the scoreboard, never depends on iss_valid; writes are never stalled.
module id_regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int CNT_W = 2,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_retire,
    input  logic                iss_valid,
    input  logic [2*AW-1:0]     iss_src,
    input  logic [1:0]          iss_use,
    input  logic                iss_wen,
    input  logic [AW-1:0]       iss_dst,
    output logic                iss_ready,
    input  logic                flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   ra;

    // Later ports overwrite earlier ones in loop order; reg 0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[rf_lo(j, AW) +: AW] != '0)
                    regs[wr_addr[rf_lo(j, AW) +: AW]] <= wr_data[rf_lo(j, XLEN) +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[rf_lo(i, AW) +: AW];
            rd_data[rf_lo(i, XLEN) +: XLEN] = regs[ra];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && ra != '0 && wr_addr[rf_lo(j, AW) +: AW] == ra)
                    rd_data[rf_lo(i, XLEN) +: XLEN] = wr_data[rf_lo(j, XLEN) +: XLEN];
            end
`endif
        end
    end

    rf_scoreboard #(
        .NREG  (NREG),
        .NRD   (NRD),
        .NWR   (NWR),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_retire (wr_retire),
        .iss_valid (iss_valid),
        .iss_src   (iss_src),
        .iss_use   (iss_use),
        .iss_wen   (iss_wen),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed and randomized checks of id_regfile_sb against a behavioural register/counter model.
module tb_id_regfile_sb;

    localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, CNT_W = 2, AW = 5, CMAX = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_retire;
    logic                iss_valid;
    logic [2*AW-1:0]     iss_src;
    logic [1:0]          iss_use;
    logic                iss_wen;
    logic [AW-1:0]       iss_dst;
    logic                iss_ready;
    logic                flush;

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] mem [NREG];
    int cnt [NREG];
    bit last_fire;

    id_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_retire(wr_retire),
        .iss_valid(iss_valid), .iss_src(iss_src), .iss_use(iss_use), .iss_wen(iss_wen),
        .iss_dst(iss_dst), .iss_ready(iss_ready), .flush(flush)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] m_rd(input int a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = mem[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic bit m_busy(input int a);
        int p;
        if (a == 0) return 1'b0;
        p = cnt[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_retire[j] && int'(wr_addr[j*AW +: AW]) == a) p = p - 1;
`endif
        return p > 0;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (iss_use[0] && m_busy(int'(iss_src[AW-1:0]))) return 1'b0;
        if (iss_use[1] && m_busy(int'(iss_src[2*AW-1:AW]))) return 1'b0;
        if (iss_wen && cnt[iss_dst] == CMAX) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model with the inputs present before the edge, then step the clock
    task automatic tick();
        bit fire;
        int nc [NREG];
        fire = iss_valid && m_ready();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin mem[r] = '0; cnt[r] = 0; end
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) mem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            for (int r = 0; r < NREG; r++) nc[r] = cnt[r];
            if (fire && iss_wen && iss_dst != 0) nc[iss_dst] = nc[iss_dst] + 1;
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_retire[j]) nc[wr_addr[j*AW +: AW]] = nc[wr_addr[j*AW +: AW]] - 1;
            for (int r = 0; r < NREG; r++) cnt[r] = (flush || nc[r] < 0) ? 0 : nc[r];
        end
        last_fire = fire && !rst;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en = '0; wr_retire = '0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_src = '0; iss_use = '0; iss_wen = 1'b0; iss_dst = '0;
        flush = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d, input bit ret);
        wr_en[j] = 1'b1; wr_addr[j*AW +: AW] = AW'(a); wr_data[j*XLEN +: XLEN] = d; wr_retire[j] = ret;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_iss(input bit v, input int rs, input int rt, input logic [1:0] u, input bit w, input int d);
        iss_valid = v; iss_src = {AW'(rt), AW'(rs)}; iss_use = u; iss_wen = w; iss_dst = AW'(d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; idle(); rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        set_rd(0, 7); set_rd(1, 31);
        #1;
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", rd_busy); end
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", iss_ready); end
    endtask

    task automatic test_write_read();
        idle(); set_wr(0, 5, 32'h1234, 0); set_rd(0, 5); #1;
        checks++; if (rd_data[XLEN-1:0] !== m_rd(5)) begin failures++; $display("FAIL wr_same_cycle got=%h exp=%h", rd_data[XLEN-1:0], m_rd(5)); end
        tick(); idle(); #1;
        checks++; if (rd_data[XLEN-1:0] !== 32'h1234) begin failures++; $display("FAIL wr_r5 got=%h exp=1234", rd_data[XLEN-1:0]); end
        set_wr(0, 0, 32'hFFFF, 0); set_rd(1, 0); #1;
        checks++; if (rd_data[2*XLEN-1:XLEN] !== '0) begin failures++; $display("FAIL r0_bypass got=%h exp=0", rd_data[2*XLEN-1:XLEN]); end
        tick(); idle(); #1;
        checks++; if (rd_data[2*XLEN-1:XLEN] !== '0) begin failures++; $display("FAIL r0_write got=%h exp=0", rd_data[2*XLEN-1:XLEN]); end
    endtask

    task automatic test_scoreboard();
        idle(); set_iss(1, 0, 0, 2'b00, 1, 8); #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sb_issue_ready got=%b exp=1", iss_ready); end
        tick(); idle(); set_rd(0, 8); set_iss(1, 8, 0, 2'b01, 0, 0); #1;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_r8_busy got=%b exp=1", rd_busy[0]); end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sb_stall got=%b exp=0", iss_ready); end
        tick();
        set_wr(0, 8, 32'h88, 1); #1;
        checks++; if (iss_ready !== m_ready()) begin failures++; $display("FAIL sb_retire_ready got=%b exp=%b", iss_ready, m_ready()); end
        tick();
        wr_en = '0; wr_retire = '0; #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sb_after_retire got=%b exp=1", iss_ready); end
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_r8_free got=%b exp=0", rd_busy[0]); end
        idle(); tick();
    endtask

    task automatic test_priority();
        idle(); set_wr(0, 3, 32'hA, 0); set_wr(1, 3, 32'hB, 0); set_rd(0, 3); #1;
        checks++; if (rd_data[XLEN-1:0] !== m_rd(3)) begin failures++; $display("FAIL prio_same_cycle got=%h exp=%h", rd_data[XLEN-1:0], m_rd(3)); end
        tick(); idle(); #1;
        checks++; if (rd_data[XLEN-1:0] !== 32'hB) begin failures++; $display("FAIL prio_r3 got=%h exp=b", rd_data[XLEN-1:0]); end
    endtask

    task automatic test_saturate();
        idle(); set_rd(1, 9);
        for (int k = 0; k < 3; k++) begin
            set_iss(1, 0, 0, 2'b00, 1, 9); #1;
            checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_issue%0d got=%b exp=1", k, iss_ready); end
            tick();
        end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_full got=%b exp=0", iss_ready); end
        checks++; if (rd_busy[1] !== 1'b1) begin failures++; $display("FAIL sat_busy got=%b exp=1", rd_busy[1]); end
        set_wr(0, 9, 32'h99, 1); #1;
        checks++; if (iss_ready !== m_ready()) begin failures++; $display("FAIL sat_retire_full got=%b exp=%b", iss_ready, m_ready()); end
        tick();
        // counter now 2: a retire and an issue together leave it at 2
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_net_ready got=%b exp=1", iss_ready); end
        tick(); idle(); set_iss(1, 0, 0, 2'b00, 1, 9); #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_net_kept got=%b exp=1", iss_ready); end
        tick(); #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_refull got=%b exp=0", iss_ready); end
        idle();
        for (int k = 0; k < 3; k++) begin set_wr(0, 9, 32'h90 + k, 1); tick(); end
        idle(); #1;
        checks++; if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL sat_drained got=%b exp=0", rd_busy[1]); end
    endtask

    task automatic test_flush();
        idle(); set_iss(1, 0, 0, 2'b00, 1, 10); tick();
        set_iss(1, 0, 0, 2'b00, 1, 11); tick();
        idle(); flush = 1'b1; set_wr(0, 12, 32'h55, 0); set_iss(1, 0, 0, 2'b00, 1, 13); #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", iss_ready); end
        tick(); idle();
        set_rd(0, 10); set_rd(1, 11); set_iss(0, 10, 11, 2'b11, 1, 10); #1;
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL flush_busy got=%b exp=00", rd_busy); end
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%b exp=1", iss_ready); end
        set_rd(0, 12); set_rd(1, 13); #1;
        checks++; if (rd_data[XLEN-1:0] !== 32'h55) begin failures++; $display("FAIL flush_write got=%h exp=55", rd_data[XLEN-1:0]); end
        checks++; if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL flush_no_issue got=%b exp=0", rd_busy[1]); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); set_iss(1, 0, 0, 2'b00, 1, 4); tick(); tick();
        set_iss(1, 4, 0, 2'b01, 0, 0); #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", iss_ready); end
        tick();
        rst = 1'b1; set_wr(0, 12, 32'h77, 0); tick(); rst = 1'b0; wr_en = '0;
        set_rd(0, 12); set_rd(1, 4); #1;
        checks++; if (rd_data[XLEN-1:0] !== '0) begin failures++; $display("FAIL rstmid_reg got=%h exp=0", rd_data[XLEN-1:0]); end
        checks++; if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", rd_busy[1]); end
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", iss_ready); end
        idle(); tick();
    endtask

    task automatic test_random();
        int avail [NREG];
        int a;
        last_fire = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < NREG; r++) avail[r] = cnt[r];
            flush = ($urandom_range(0, 19) == 0);
            set_rd(0, $urandom_range(0, 31)); set_rd(1, $urandom_range(0, 31));
            wr_en = '0; wr_retire = '0;
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 31);
                    set_wr(j, a, $urandom, 0);
                    if (avail[a] > 0 && $urandom_range(0, 1) == 1) begin
                        wr_retire[j] = 1'b1; avail[a] = avail[a] - 1;
                    end
                end
            end
            if (!(iss_valid && !last_fire))
                set_iss($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                        2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 31));
            #1;
            for (int i = 0; i < NRD; i++) begin
                checks++;
                if (rd_data[i*XLEN +: XLEN] !== m_rd(int'(rd_addr[i*AW +: AW]))) begin
                    failures++; $display("FAIL rand_rd%0d cyc=%0d got=%h exp=%h", i, cyc, rd_data[i*XLEN +: XLEN], m_rd(int'(rd_addr[i*AW +: AW])));
                end
                checks++;
                if (rd_busy[i] !== m_busy(int'(rd_addr[i*AW +: AW]))) begin
                    failures++; $display("FAIL rand_busy%0d cyc=%0d got=%b exp=%b", i, cyc, rd_busy[i], m_busy(int'(rd_addr[i*AW +: AW])));
                end
            end
            checks++;
            if (iss_ready !== m_ready()) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, iss_ready, m_ready());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin mem[r] = '0; cnt[r] = 0; end
        last_fire = 1'b0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_priority();
        test_saturate();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
